medac_wr_ctrl: RTL and testbench

Write-side controller for the metastability-detecting dual-clock FIFO, in the `wclk` domain. It accepts an upstream valid/ready stream and drives the FIFO write port (`winc`/`wdata`) while respecting `wfull`. It reacts to the read-to-write synchronizer error flag `error_w`: it blocks writes for a guard window, raises the synchronizer depth (`sync_sel`), and lowers the depth again after a long error-free window. It also counts detected errors for software.

---
 rtl/medac_pkg.sv | 14 +
 rtl/medac_sel_adapt.sv | 67 ++++++
 rtl/medac_wr_ctrl.sv | 94 +++++++++
 tb/tb_medac_wr_ctrl.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/medac_pkg.sv
// Shared types and constants for the medac write-side controller.
package medac_pkg;

    // Write-side FSM states.
    typedef enum logic {
        GUARD = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Synchronizer tap select width and its top value.
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_MAX = 3'd7;

endpackage

// File: rtl/medac_sel_adapt.sv
// Synchronizer-depth adapter: clean-window counter, saturating sync_sel and the
// saturating error counter. sel_up/sel_dn pulse in the cycle that changes sync_sel.
module medac_sel_adapt
    import medac_pkg::*;
#(
    parameter int CLEAN_WIN = 1024,
    parameter int SEL_MIN   = 1,
    parameter int SEL_RST   = 1,
    parameter int ECNT_W    = 16
) (
    input  logic              wclk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              error_w,
    input  logic              adapt_en,
    output logic [SEL_W-1:0]  sync_sel,
    output logic [ECNT_W-1:0] err_cnt,
    output logic              sel_up,
    output logic              sel_dn
);

    localparam int CW = (CLEAN_WIN > 1) ? $clog2(CLEAN_WIN) : 1;
    localparam logic [CW-1:0] CLEAN_LAST = CW'(CLEAN_WIN - 1);
    localparam logic [SEL_W-1:0] SEL_LO = SEL_W'(SEL_MIN);
    localparam logic [SEL_W-1:0] SEL_INIT = SEL_W'(SEL_RST);

    logic [CW-1:0] clean_cnt;
    logic          win_done;

    // An error in the same cycle as window expiry suppresses the decrement.
    assign win_done = run & ~error_w & (clean_cnt == CLEAN_LAST);
    assign sel_up   = run & error_w & adapt_en & (sync_sel < SEL_MAX);
    assign sel_dn   = win_done & adapt_en & (sync_sel > SEL_LO);

    // Clean-window counter: counts error-free RUN cycles, holds at the last value
    // when no decrement is possible, clears on any error or on a decrement.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            clean_cnt <= '0;
        end else if (error_w || sel_dn) begin
            clean_cnt <= '0;
        end else if (run && (clean_cnt != CLEAN_LAST)) begin
            clean_cnt <= clean_cnt + 1'b1;
        end
    end

    // Synchronizer depth: saturating step up on error, step down on a clean window.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sel <= SEL_INIT;
        end else if (sel_up) begin
            sync_sel <= sync_sel + 1'b1;
        end else if (sel_dn) begin
            sync_sel <= sync_sel - 1'b1;
        end
    end

    // Saturating count of cycles with error_w high, in either state.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (error_w && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/medac_wr_ctrl.sv
// Write-side controller for the metastability-detecting dual-clock FIFO.
// Gates the upstream handshake, holds off writes in a guard window after
// synchronizer errors or tap changes, and drives the adaptive sync_sel.
module medac_wr_ctrl
    import medac_pkg::*;
#(
    parameter int DSIZE     = 40,
    parameter int GUARD_CYC = 8,
    parameter int CLEAN_WIN = 1024,
    parameter int SEL_MIN   = 1,
    parameter int SEL_RST   = 1,
    parameter int ECNT_W    = 16
) (
    input  logic              wclk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              adapt_en,
    input  logic              in_valid,
    input  logic [DSIZE-1:0]  in_data,
    output logic              in_ready,
    output logic              winc,
    output logic [DSIZE-1:0]  wdata,
    input  logic              wfull,
    input  logic              error_w,
    output logic [SEL_W-1:0]  sync_sel,
    output logic [ECNT_W-1:0] err_cnt,
    output logic              guard
);

    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC - 1);

    state_t        state;
    logic [GW-1:0] guard_cnt;
    logic          run;
    logic          sel_up;
    logic          sel_dn;
    logic          enter_guard;

    assign run   = (state == RUN);
    assign guard = (state == GUARD);

    // Zero-latency handshake; error_w blocks the write in the cycle it is seen.
    assign in_ready = en & run & ~wfull & ~error_w;
    assign winc     = in_valid & in_ready;
    assign wdata    = in_data;

    // Any tap change can glitch the synchronized read pointer, so it forces GUARD.
    assign enter_guard = error_w | sel_up | sel_dn;

    // FSM with guard down-counter; an error inside GUARD restarts the window.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= GUARD;
            guard_cnt <= GUARD_LOAD;
        end else begin
            unique case (state)
                GUARD: begin
                    if (error_w) begin
                        guard_cnt <= GUARD_LOAD;
                    end else if (guard_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        guard_cnt <= guard_cnt - 1'b1;
                    end
                end
                RUN: begin
                    if (enter_guard) begin
                        state     <= GUARD;
                        guard_cnt <= GUARD_LOAD;
                    end
                end
            endcase
        end
    end

    medac_sel_adapt #(
        .CLEAN_WIN (CLEAN_WIN),
        .SEL_MIN   (SEL_MIN),
        .SEL_RST   (SEL_RST),
        .ECNT_W    (ECNT_W)
    ) u_sel_adapt (
        .wclk     (wclk),
        .rst_n    (rst_n),
        .run      (run),
        .error_w  (error_w),
        .adapt_en (adapt_en),
        .sync_sel (sync_sel),
        .err_cnt  (err_cnt),
        .sel_up   (sel_up),
        .sel_dn   (sel_dn)
    );

endmodule

// File: tb/tb_medac_wr_ctrl.sv
// Self-checking bench for medac_wr_ctrl against a cycle-level behavioural model.
module tb_medac_wr_ctrl;

    localparam int DW      = 40;
    localparam int GC      = 8;
    localparam int CWIN    = 16;
    localparam int SMIN    = 1;
    localparam int SRST    = 1;
    localparam int ECW     = 4;
    localparam int ERR_MAX = (1 << ECW) - 1;

    logic          wclk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          adapt_en;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          wfull;
    logic          error_w;
    logic [2:0]    sync_sel;
    logic [ECW-1:0] err_cnt;
    logic          guard;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: guard cycles still to serve, clean RUN cycles seen, depth, errors.
    int m_gl;
    int m_clean;
    int m_sel;
    int m_err;

    logic [9:0] dut_vec;
    assign dut_vec = {in_ready, winc, guard, sync_sel, err_cnt};

    medac_wr_ctrl #(
        .DSIZE     (DW),
        .GUARD_CYC (GC),
        .CLEAN_WIN (CWIN),
        .SEL_MIN   (SMIN),
        .SEL_RST   (SRST),
        .ECNT_W    (ECW)
    ) dut (
        .wclk     (wclk),
        .rst_n    (rst_n),
        .en       (en),
        .adapt_en (adapt_en),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .winc     (winc),
        .wdata    (wdata),
        .wfull    (wfull),
        .error_w  (error_w),
        .sync_sel (sync_sel),
        .err_cnt  (err_cnt),
        .guard    (guard)
    );

    always #5 wclk = ~wclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DW-1:0];
    endfunction

    task automatic model_reset();
        m_gl    = GC;
        m_clean = 0;
        m_sel   = SRST;
        m_err   = 0;
    endtask

    // Expected {in_ready, winc, guard, sync_sel, err_cnt} for current inputs.
    function automatic logic [9:0] exp_vec();
        logic rn;
        logic rdy;
        rn  = (m_gl == 0);
        rdy = en & rn & ~wfull & ~error_w;
        return {rdy, rdy & in_valid, ~rn, 3'(m_sel), 4'(m_err)};
    endfunction

    // One clock edge of behaviour, from the written rules.
    task automatic model_step();
        if (error_w) m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
        if (m_gl > 0) begin
            if (error_w) m_gl = GC;
            else m_gl = m_gl - 1;
        end else if (error_w) begin
            if (adapt_en && m_sel < 7) m_sel = m_sel + 1;
            m_gl    = GC;
            m_clean = 0;
        end else begin
            m_clean = m_clean + 1;
            if (m_clean >= CWIN) begin
                if (adapt_en && m_sel > SMIN) begin
                    m_sel   = m_sel - 1;
                    m_gl    = GC;
                    m_clean = 0;
                end else begin
                    m_clean = CWIN;
                end
            end
        end
    endtask

    // Inputs only change at negedge, so model and DUT see the same values.
    task automatic advance();
        @(posedge wclk);
        if (rst_n) model_step();
        @(negedge wclk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) advance();
    endtask

    task automatic do_reset();
        @(negedge wclk);
        rst_n = 1'b0; en = 1'b1; adapt_en = 1'b1; in_valid = 1'b0;
        in_data = '0; wfull = 1'b0; error_w = 1'b0;
        model_reset();
        @(negedge wclk);
        @(negedge wclk);
        rst_n = 1'b1;
    endtask

    task automatic raise_sel(input int n);
        for (int i = 0; i < n; i++) begin
            error_w = 1'b1;
            advance();
            error_w = 1'b0;
            idle(GC);
        end
    endtask

    task automatic test_reset();
        int first_edge;
        first_edge = -1;
        @(negedge wclk);
        rst_n = 1'b0; en = 1'b1; adapt_en = 1'b1; in_valid = 1'b1;
        wfull = 1'b0; error_w = 1'b0; in_data = rand_word();
        model_reset();
        #1;
        n_tests++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h", dut_vec, exp_vec());
        end
        @(negedge wclk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = rand_word();
            #1;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_release cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (winc === 1'b1 && first_edge < 0) first_edge = i + 1;
            advance();
        end
        n_tests++;
        if (first_edge != GC + 1) begin
            n_fail++;
            $display("FAIL first_write_edge: got %0d want %0d", first_edge, GC + 1);
        end
    endtask

    task automatic test_stream();
        logic [DW-1:0] words [20];
        int acc, full_cyc, total;
        acc = 0; full_cyc = 0; total = -1;
        do_reset();
        idle(GC);
        for (int i = 0; i < 20; i++) words[i] = rand_word();
        for (int c = 0; c < 60 && acc < 20; c++) begin
            wfull = (acc >= 16) && (full_cyc < 4);
            if (wfull) full_cyc++;
            in_valid = 1'b1;
            in_data  = words[acc];
            #1;
            n_tests++;
            if (dut_vec !== exp_vec() || wdata !== words[acc]) begin
                n_fail++;
                $display("FAIL stream cyc %0d: got %h/%h want %h/%h", c, dut_vec, wdata,
                         exp_vec(), words[acc]);
            end
            if (winc === 1'b1) begin
                acc++;
                if (acc == 20) total = c + 1;
            end
            advance();
        end
        wfull = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (acc != 20 || total != 24) begin
            n_fail++;
            $display("FAIL stream_count: got %0d words in %0d cyc want 20 in 24", acc, total);
        end
    endtask

    task automatic test_error_single();
        int gcount;
        gcount = 0;
        do_reset();
        idle(GC);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            error_w  = (i == 3);
            in_data  = rand_word();
            #1;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL err_single pre %0d: got %h want %h", i, dut_vec, exp_vec());
            end
            advance();
        end
        error_w = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL err_single post %0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (guard === 1'b1) gcount++;
            advance();
        end
        n_tests++;
        if (gcount != GC || sync_sel !== 3'd2 || err_cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL err_single_sum: got g=%0d sel=%0d cnt=%0d want g=%0d sel=2 cnt=1",
                     gcount, sync_sel, err_cnt, GC);
        end
    endtask

    task automatic test_sel_saturate();
        int gcount;
        gcount = 0;
        do_reset();
        idle(GC);
        raise_sel(5);
        for (int p = 0; p < 8; p++) begin
            int gap;
            gap = (p == 0) ? 0 : $urandom_range(0, 10);
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'($urandom_range(0, 1));
                #1;
                n_tests++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++;
                    $display("FAIL sat_gap p%0d: got %h want %h", p, dut_vec, exp_vec());
                end
                advance();
            end
            error_w = 1'b1;
            #1;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL sat_pulse p%0d: got %h want %h", p, dut_vec, exp_vec());
            end
            advance();
            error_w = 1'b0;
        end
        for (int i = 0; i < GC + 3; i++) begin
            if (guard === 1'b1) gcount++;
            advance();
        end
        n_tests++;
        if (sync_sel !== 3'd7 || err_cnt !== 4'd13 || gcount != GC) begin
            n_fail++;
            $display("FAIL sat_sum: got sel=%0d cnt=%0d g=%0d want sel=7 cnt=13 g=%0d",
                     sync_sel, err_cnt, gcount, GC);
        end
    endtask

    task automatic test_clean_window();
        int decs, gcount;
        logic [2:0] prev;
        decs = 0; gcount = 0;
        do_reset();
        idle(GC);
        raise_sel(2);
        prev = sync_sel;
        for (int i = 0; i < 110; i++) begin
            en       = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            wfull    = ($urandom_range(0, 3) == 0);
            in_data  = rand_word();
            #1;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL clean cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
            if (sync_sel < prev) decs++;
            if (guard === 1'b1) gcount++;
            prev = sync_sel;
            advance();
        end
        en = 1'b1; wfull = 1'b0;
        n_tests++;
        if (decs != 2 || sync_sel !== 3'd1 || gcount != 2 * GC) begin
            n_fail++;
            $display("FAIL clean_sum: got dec=%0d sel=%0d g=%0d want dec=2 sel=1 g=%0d",
                     decs, sync_sel, gcount, 2 * GC);
        end
    endtask

    task automatic test_collision();
        do_reset();
        idle(GC);
        raise_sel(2);
        for (int i = 0; i < CWIN; i++) begin
            error_w  = (i == CWIN - 1);
            in_valid = 1'b1;
            #1;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL collide cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
            advance();
        end
        error_w = 1'b0;
        #1;
        n_tests++;
        if (sync_sel !== 3'd4 || guard !== 1'b1) begin
            n_fail++;
            $display("FAIL collide_sel: got sel=%0d guard=%b want sel=4 guard=1", sync_sel, guard);
        end
        adapt_en = 1'b0;
        for (int i = 0; i < 60; i++) begin
            error_w  = (i < 30) && ($urandom_range(0, 3) == 0);
            in_valid = 1'($urandom_range(0, 1));
            #1;
            n_tests++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL no_adapt cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
            advance();
        end
        error_w = 1'b0;
        n_tests++;
        if (sync_sel !== 3'd4) begin
            n_fail++;
            $display("FAIL no_adapt_sel: got %0d want 4", sync_sel);
        end
    endtask

    task automatic test_random_reset();
        do_reset();
        for (int i = 0; i < 80; i++) begin
            en       = 1'($urandom_range(0, 1));
            adapt_en = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            wfull    = ($urandom_range(0, 3) == 0);
            error_w  = 1'($urandom_range(0, 1));
            in_data  = rand_word();
            #1;
            n_tests++;
            if (dut_vec !== exp_vec() || wdata !== in_data) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h want %h", i, dut_vec, exp_vec());
            end
            advance();
        end
        n_tests++;
        if (err_cnt !== 4'(ERR_MAX)) begin
            n_fail++;
            $display("FAIL err_saturate: got %0d want %0d", err_cnt, ERR_MAX);
        end
        // Reset dropped between edges with a write being offered.
        en = 1'b1; wfull = 1'b0; error_w = 1'b0; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", dut_vec, exp_vec());
        end
        @(posedge wclk);
        #1;
        n_tests++;
        if (winc !== 1'b0 || guard !== 1'b1) begin
            n_fail++;
            $display("FAIL in_reset_write: got winc=%b guard=%b want 0/1", winc, guard);
        end
        @(negedge wclk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; adapt_en = 1'b0; in_valid = 1'b0;
        in_data = '0; wfull = 1'b0; error_w = 1'b0;
        model_reset();
        test_reset();
        test_stream();
        test_error_single();
        test_sel_saturate();
        test_clean_window();
        test_collision();
        test_random_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
